// File: rtl/ooo_read_slave.sv
// rtl/ooo_read_slave.sv - AXI-style read target with ID-dependent latency and oldest-first response pick.
// Define OOO_SLAVE_INORDER_EN to give every ID the same latency, so responses return in accept order.
module ooo_read_slave #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int BASE_LAT   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            s_arid_i,
   input  logic                  s_arvalid_i,
   output logic                  s_arready_o,
   output logic [DATA_WIDTH-1:0] s_rdata_o,
   output logic [3:0]            s_rid_o,
   output logic                  s_rvalid_o,
   input  logic                  s_rready_i
);

   localparam int CW = $clog2(BASE_LAT + 16);
   localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0]      slot_valid;
   logic [3:0]            slot_id   [DEPTH];
   logic [CW-1:0]         slot_cnt  [DEPTH];
   logic [DATA_WIDTH-1:0] slot_data [DEPTH];
   // age[j][k] = 1 means slot j was allocated before slot k
   logic [DEPTH-1:0]      age       [DEPTH];
   logic [15:0]           seq;

   logic [DEPTH-1:0]      slot_ready;
   logic [DEPTH-1:0]      pick_ok;
   logic                  alloc_found;
   logic [SW-1:0]         alloc_idx;
   logic                  pick_found;
   logic [SW-1:0]         pick_idx;
   logic                  accept;
   logic                  load_en;
   logic                  do_pick;
   logic [CW-1:0]         new_cnt;

   assign s_arready_o = ~(&slot_valid);
   assign accept      = s_arvalid_i & s_arready_o;
   assign load_en     = ~s_rvalid_o | s_rready_i;
   assign do_pick     = load_en & pick_found;

`ifdef OOO_SLAVE_INORDER_EN
   assign new_cnt = CW'(BASE_LAT);
`else
   assign new_cnt = CW'(BASE_LAT) + CW'(s_arid_i);
`endif

   always_comb begin
      alloc_found = 1'b0;
      alloc_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!slot_valid[i]) begin
            alloc_found = 1'b1;
            alloc_idx   = SW'(i);
         end
      end
   end

   always_comb begin
      slot_ready = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_ready[i] = slot_valid[i] && (slot_cnt[i] == '0);
      end
   end

   // A ready slot is picked only if no other ready slot is older than it
   always_comb begin
      pick_ok    = '0;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         pick_ok[i] = slot_ready[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (slot_ready[j] && age[j][i]) begin
               pick_ok[i] = 1'b0;
            end
         end
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (pick_ok[i]) begin
            pick_found = 1'b1;
            pick_idx   = SW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_valid <= '0;
         seq        <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            slot_id[i]   <= '0;
            slot_cnt[i]  <= '0;
            slot_data[i] <= '0;
            age[i]       <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (accept && alloc_found && (alloc_idx == SW'(i))) begin
               slot_valid[i] <= 1'b1;
               slot_id[i]    <= s_arid_i;
               slot_cnt[i]   <= new_cnt;
               slot_data[i]  <= seq[DATA_WIDTH-1:0];
            end else begin
               if (do_pick && (pick_idx == SW'(i))) begin
                  slot_valid[i] <= 1'b0;
               end
               if (slot_valid[i] && (slot_cnt[i] != '0)) begin
                  slot_cnt[i] <= slot_cnt[i] - 1'b1;
               end
            end
         end
         if (accept) begin
            seq <= seq + 16'd1;
            for (int j = 0; j < DEPTH; j++) begin
               for (int k = 0; k < DEPTH; k++) begin
                  if (alloc_idx == SW'(j)) begin
                     age[j][k] <= 1'b0;
                  end else if (alloc_idx == SW'(k)) begin
                     age[j][k] <= slot_valid[j];
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_rvalid_o <= 1'b0;
         s_rid_o    <= '0;
         s_rdata_o  <= '0;
      end else if (load_en) begin
         if (pick_found) begin
            s_rvalid_o <= 1'b1;
            s_rid_o    <= slot_id[pick_idx];
            s_rdata_o  <= slot_data[pick_idx];
         end else begin
            s_rvalid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ooo_read_slave.sv
// tb/tb_ooo_read_slave.sv - Randomized and directed bench against a queue-based reference model.
module tb_ooo_read_slave;

   localparam int DATA_WIDTH = 8;
   localparam int DEPTH      = 4;
   localparam int BASE_LAT   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [3:0]            s_arid_i;
   logic                  s_arvalid_i;
   logic                  s_arready_o;
   logic [DATA_WIDTH-1:0] s_rdata_o;
   logic [3:0]            s_rid_o;
   logic                  s_rvalid_o;
   logic                  s_rready_i;

   ooo_read_slave #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .BASE_LAT   (BASE_LAT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_arid_i    (s_arid_i),
      .s_arvalid_i (s_arvalid_i),
      .s_arready_o (s_arready_o),
      .s_rdata_o   (s_rdata_o),
      .s_rid_o     (s_rid_o),
      .s_rvalid_o  (s_rvalid_o),
      .s_rready_i  (s_rready_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int data;
      int elig;
   } req_t;

   // Outstanding requests in accept order; elig is the first edge at which the response may load
   req_t q[$];
   int   edge_n;
   int   seq_m;
   bit   m_rvalid;
   int   m_rid;
   int   m_rdata;
   int   n_checks;
   int   n_errors;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int lat(input int id);
`ifdef OOO_SLAVE_INORDER_EN
      return BASE_LAT;
`else
      return BASE_LAT + id;
`endif
   endfunction

   task automatic check_outputs();
      check_eq("arready", s_arready_o, (q.size() < DEPTH));
      check_eq("rvalid", s_rvalid_o, m_rvalid);
      check_eq("rid", s_rid_o, m_rid);
      check_eq("rdata", s_rdata_o, m_rdata);
   endtask

   // Called at a negedge: check, drive, update model for the next posedge, advance to next negedge
   task automatic cycle(input bit av, input int aid, input bit rr);
      bit acc;
      int pi;
      check_outputs();
      s_arvalid_i = av;
      s_arid_i    = aid[3:0];
      s_rready_i  = rr;
      edge_n++;
      acc = av && (q.size() < DEPTH);
      if (!m_rvalid || rr) begin
         pi = -1;
         foreach (q[i]) begin
            if (pi < 0 && q[i].elig <= edge_n) pi = i;
         end
         if (pi >= 0) begin
            m_rvalid = 1'b1;
            m_rid    = q[pi].id;
            m_rdata  = q[pi].data;
            q.delete(pi);
         end else begin
            m_rvalid = 1'b0;
         end
      end
      if (acc) begin
         q.push_back('{aid & 15, seq_m & 255, edge_n + lat(aid & 15) + 1});
         seq_m = (seq_m + 1) & 16'hFFFF;
      end
      @(negedge clk);
   endtask

   task automatic reset_pulse();
      rst_n       = 1'b0;
      s_arvalid_i = 1'($urandom);
      s_arid_i    = 4'($urandom);
      s_rready_i  = 1'($urandom);
      #1;
      q.delete();
      seq_m    = 0;
      m_rvalid = 1'b0;
      m_rid    = 0;
      m_rdata  = 0;
      check_eq("rst_rvalid", s_rvalid_o, 1'b0);
      check_eq("rst_arready", s_arready_o, 1'b1);
      check_eq("rst_rid", s_rid_o, 4'h0);
      check_eq("rst_rdata", s_rdata_o, 8'h00);
      @(negedge clk);
      edge_n++;
      rst_n = 1'b1;
   endtask

   task automatic idle(input int n, input bit rr);
      for (int i = 0; i < n; i++) cycle(1'b0, 0, rr);
   endtask

   initial begin
      int rprob;
      n_checks    = 0;
      n_errors    = 0;
      edge_n      = 0;
      seq_m       = 0;
      m_rvalid    = 1'b0;
      m_rid       = 0;
      m_rdata     = 0;
      rst_n       = 1'b0;
      s_arvalid_i = 1'b0;
      s_arid_i    = '0;
      s_rready_i  = 1'b1;
      @(negedge clk);
      reset_pulse();

      // single request, latency and one-beat pulse
      cycle(1'b1, 3, 1'b1);
      idle(10, 1'b1);

      // later-issued short-latency ID overtakes
      cycle(1'b1, 5, 1'b1);
      cycle(1'b1, 0, 1'b1);
      idle(20, 1'b1);

      // same ID under a long stall keeps order and holds data
      reset_pulse();
      cycle(1'b1, 2, 1'b0);
      cycle(1'b1, 2, 1'b0);
      idle(10, 1'b0);
      idle(8, 1'b1);

      // fill the table, then free one slot with a single handshake
      reset_pulse();
      for (int i = 0; i < 4; i++) cycle(1'b1, i, 1'b0);
      cycle(1'b1, 7, 1'b0);
      idle(20, 1'b0);
      cycle(1'b0, 0, 1'b1);
      cycle(1'b1, 9, 1'b0);
      idle(30, 1'b1);

      // reset mid-countdown drops everything
      for (int i = 0; i < 3; i++) cycle(1'b1, 4 + i, 1'b1);
      idle(2, 1'b1);
      reset_pulse();
      cycle(1'b1, 0, 1'b1);
      idle(10, 1'b1);

      // randomized traffic with varying back-pressure
      for (int phase = 0; phase < 6; phase++) begin
         rprob = (phase % 3 == 0) ? 100 : ((phase % 3 == 1) ? 50 : 15);
         for (int c = 0; c < 600; c++) begin
            cycle(($urandom_range(99) < 60), int'($urandom_range(15)),
                  ($urandom_range(99) < rprob));
         end
         if (phase == 3) reset_pulse();
      end
      idle(60, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
